// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - issue/commit sequencer around an external 4-bit ALU
// Optional sticky-overflow flag enabled by defining ALU_SEQ_STICKY_V_EN.
module alu_issue_seq #(
  parameter int          ADDR_W    = 2,
  parameter logic [3:0]  RESET_VAL = 4'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_srca,
  input  logic [ADDR_W-1:0] in_srcb,
  input  logic [ADDR_W-1:0] in_dst,
  input  logic              in_imm_en,
  input  logic [3:0]        in_imm,
  input  logic              in_nowb,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  output logic [3:0]        alu_opcode,
  input  logic [3:0]        alu_out,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  input  logic              alu_p,
  output logic [3:0]        flags_q,
  output logic              done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        rd_data,
  input  logic              clr_sticky,
  output logic              sticky_v
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t              state_q;
  logic [3:0]          rf_q [DEPTH];
  logic [3:0]          op_q;
  logic [ADDR_W-1:0]   srca_q;
  logic [ADDR_W-1:0]   srcb_q;
  logic [ADDR_W-1:0]   dst_q;
  logic                imm_en_q;
  logic [3:0]          imm_q;
  logic                nowb_q;
  logic [3:0]          res_q;
  logic [3:0]          rflags_q;

  // Ready is a pure decode of the state register, so it reads 1 throughout reset.
  assign in_ready = (state_q == IDLE);

  // Debug read port sees the committed register file with no extra latency.
  assign rd_data = rf_q[rd_addr];

  // Sequencer: accept, read operands, capture ALU result, commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= RESET_VAL;
      op_q       <= '0;
      srca_q     <= '0;
      srcb_q     <= '0;
      dst_q      <= '0;
      imm_en_q   <= 1'b0;
      imm_q      <= '0;
      nowb_q     <= 1'b0;
      res_q      <= '0;
      rflags_q   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      flags_q    <= '0;
      done       <= 1'b0;
`ifdef ALU_SEQ_STICKY_V_EN
      sticky_v   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef ALU_SEQ_STICKY_V_EN
      // Clear first so that a same-edge overflow commit below takes priority.
      if (clr_sticky) sticky_v <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q     <= in_op;
            srca_q   <= in_srca;
            srcb_q   <= in_srcb;
            dst_q    <= in_dst;
            imm_en_q <= in_imm_en;
            imm_q    <= in_imm;
            nowb_q   <= in_nowb;
            state_q  <= READ;
          end
        end
        READ: begin
          alu_a      <= rf_q[srca_q];
          alu_b      <= imm_en_q ? imm_q : rf_q[srcb_q];
          alu_opcode <= op_q;
          state_q    <= EXEC;
        end
        EXEC: begin
          res_q    <= alu_out;
          rflags_q <= {alu_z, alu_c, alu_v, alu_p};
          state_q  <= WB;
        end
        WB: begin
          if (!nowb_q) rf_q[dst_q] <= res_q;
          flags_q <= rflags_q;
          done    <= 1'b1;
`ifdef ALU_SEQ_STICKY_V_EN
          if (rflags_q[1]) sticky_v <= 1'b1;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef ALU_SEQ_STICKY_V_EN
  assign sticky_v = 1'b0;
  wire unused_clr_sticky = clr_sticky;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - randomized self-checking bench for alu_issue_seq
module tb_alu_issue_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [1:0] in_srca, in_srcb, in_dst;
  logic       in_imm_en;
  logic [3:0] in_imm;
  logic       in_nowb;
  logic [3:0] alu_a, alu_b, alu_opcode, alu_out;
  logic       alu_z, alu_c, alu_v, alu_p;
  logic [3:0] flags_q;
  logic       done;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;
  logic       clr_sticky;
  logic       sticky_v;

  int checks   = 0;
  int failures = 0;

  logic [3:0] m_rf [4];
  logic [3:0] m_flags;
  logic       m_sticky;

  always #5 clk = ~clk;

  alu_issue_seq #(.ADDR_W(2), .RESET_VAL(4'h0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_srca(in_srca), .in_srcb(in_srcb), .in_dst(in_dst),
    .in_imm_en(in_imm_en), .in_imm(in_imm), .in_nowb(in_nowb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .alu_p(alu_p),
    .flags_q(flags_q), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .clr_sticky(clr_sticky), .sticky_v(sticky_v)
  );

  // Toy ALU: returns {out[3:0], z, c, v, p}
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] o;
    logic c, v, p;
    c = 1'b0; v = 1'b0; p = 1'b0;
    case (op)
      4'h1: o = a & b;
      4'h2: o = a | b;
      4'h3: o = a ^ b;
      4'h4: begin
        s = {1'b0, a} + {1'b0, b};
        o = s[3:0]; c = s[4];
        v = (a[3] == b[3]) && (o[3] != a[3]);
      end
      4'h5: begin
        s = {1'b0, a} - {1'b0, b};
        o = s[3:0]; c = s[4];
        v = (a[3] != b[3]) && (o[3] != a[3]);
      end
      4'h8: o = b;
      default: begin o = a; p = ^a; end
    endcase
    return {o, (o == 4'h0), c, v, p};
  endfunction

  always_comb {alu_out, alu_z, alu_c, alu_v, alu_p} = alu_f(alu_opcode, alu_a, alu_b);

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 4'h0;
    m_flags  = 4'h0;
    m_sticky = 1'b0;
  endtask

  // One instruction, starting and ending on a falling edge in IDLE.
  task automatic issue(input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [1:0] d, input logic ie, input logic [3:0] im, input logic nw);
    logic [3:0] a, b;
    logic [7:0] r;
    a = m_rf[sa];
    b = ie ? im : m_rf[sb];
    r = alu_f(op, a, b);
    in_valid = 1'b1; in_op = op; in_srca = sa; in_srcb = sb; in_dst = d;
    in_imm_en = ie; in_imm = im; in_nowb = nw;
    chk("ready_idle", 8'(in_ready), 8'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    in_op = 4'($urandom); in_srca = 2'($urandom); in_srcb = 2'($urandom);
    in_dst = 2'($urandom); in_imm_en = 1'($urandom); in_imm = 4'($urandom); in_nowb = 1'($urandom);
    chk("ready_read", 8'(in_ready), 8'd0);
    chk("done_read", 8'(done), 8'd0);
    @(posedge clk); @(negedge clk);
    chk("exec_a", 8'(alu_a), 8'(a));
    chk("exec_b", 8'(alu_b), 8'(b));
    chk("exec_op", 8'(alu_opcode), 8'(op));
    chk("ready_exec", 8'(in_ready), 8'd0);
    rd_addr = d;
    @(posedge clk); @(negedge clk);
    chk("wb_rd_old", 8'(rd_data), 8'(m_rf[d]));
    chk("done_wb", 8'(done), 8'd0);
    @(posedge clk); @(negedge clk);
    if (!nw) m_rf[d] = r[7:4];
    m_flags = r[3:0];
`ifdef ALU_SEQ_STICKY_V_EN
    if (r[1]) m_sticky = 1'b1;
`endif
    chk("done_commit", 8'(done), 8'd1);
    chk("flags_commit", 8'(flags_q), 8'(m_flags));
    chk("rd_commit", 8'(rd_data), 8'(m_rf[d]));
    chk("sticky_commit", 8'(sticky_v), 8'(m_sticky));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_cnt, done_cnt;
    rst_n = 1'b0; in_valid = 1'b1; in_op = 4'h4; in_srca = 2'd0; in_srcb = 2'd0;
    in_dst = 2'd1; in_imm_en = 1'b1; in_imm = 4'h7; in_nowb = 1'b0;
    rd_addr = 2'd0; clr_sticky = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", 8'(in_ready), 8'd1);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_flags", 8'(flags_q), 8'd0);
    chk("rst_alu_a", 8'(alu_a), 8'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1 chk("rst_rf", 8'(rd_data), 8'd0);
    end
    chk("rst_sticky", 8'(sticky_v), 8'd0);

    // Directed: immediate seed, register add with overflow, no-writeback AND
    issue(4'h8, 2'd0, 2'd0, 2'd1, 1'b1, 4'h5, 1'b0);
    chk("seed_r1", 8'(rd_data), 8'h05);
    issue(4'h8, 2'd0, 2'd0, 2'd2, 1'b1, 4'h3, 1'b0);
    issue(4'h4, 2'd1, 2'd2, 2'd3, 1'b0, 4'h0, 1'b0);
    chk("add_r3", 8'(rd_data), 8'h08);
    chk("add_flags", 8'(flags_q), 8'b0010);
    issue(4'h1, 2'd3, 2'd0, 2'd3, 1'b1, 4'h0, 1'b1);
    chk("nowb_r3", 8'(rd_data), 8'h08);
    chk("nowb_flags", 8'(flags_q), 8'b1000);
`ifdef ALU_SEQ_STICKY_V_EN
    chk("sticky_hold", 8'(sticky_v), 8'd1);
`else
    chk("sticky_off", 8'(sticky_v), 8'd0);
`endif
    clr_sticky = 1'b1;
    @(posedge clk); @(negedge clk);
    clr_sticky = 1'b0;
`ifdef ALU_SEQ_STICKY_V_EN
    m_sticky = 1'b0;
`endif
    chk("sticky_clr", 8'(sticky_v), 8'(m_sticky));

    // Randomized instructions against the model
    for (int n = 0; n < 24; n++) begin
      issue(4'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
            1'($urandom), 4'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    // Continuous valid: accepts exactly every 4th cycle
    @(posedge clk); @(negedge clk);
    in_valid = 1'b1; in_op = 4'h4; in_srca = 2'd1; in_srcb = 2'd2; in_dst = 2'd0;
    in_imm_en = 1'b0; in_imm = 4'h0; in_nowb = 1'b1;
    rdy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (in_ready) rdy_cnt++;
      if (done) done_cnt++;
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    m_flags = alu_f(4'h4, m_rf[1], m_rf[2]) ;
    chk("stream_accepts", 8'(rdy_cnt), 8'd4);
    chk("stream_dones", 8'(done_cnt), 8'd3);
    chk("stream_done_last", 8'(done), 8'd1);
    chk("stream_flags", 8'(flags_q), 8'(m_flags[3:0]));
    rd_addr = 2'd0;
    #1 chk("stream_nowb", 8'(rd_data), 8'(m_rf[0]));

    // Reset during EXEC aborts the instruction
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'h8; in_imm_en = 1'b1; in_imm = 4'h9; in_dst = 2'd2; in_nowb = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort_exec_b", 8'(alu_b), 8'h09);
    rst_n = 1'b0;
    model_reset();
    rd_addr = 2'd1;
    #1;
    chk("abort_alu_b", 8'(alu_b), 8'd0);
    chk("abort_flags", 8'(flags_q), 8'd0);
    chk("abort_rf", 8'(rd_data), 8'd0);
    chk("abort_ready", 8'(in_ready), 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", 8'(done_cnt), 8'd0);
    rd_addr = 2'd2;
    #1 chk("abort_no_write", 8'(rd_data), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Sequencing stage wrapped around the team's combinational 4-bit ALU.
- Holds a small operand register file and accepts one instruction at a time over a valid/ready handshake.
- Drives registered A/B/Opcode into the ALU, captures its Out and Z/C/V/P flags, and writes the result back plus a flag register.
- Sits directly upstream (operand/opcode source) and downstream (result/flag consumer) of the ALU. The ALU itself is instantiated outside this block.

Parameters:
- ADDR_W, 2, register-index width; register file depth = 2**ADDR_W entries of 4 bits.
- RESET_VAL, 4'h0, reset value of every register-file entry.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  block can accept; equals (state==IDLE).
- in_op  in  4  ALU opcode.
- in_srca  in  ADDR_W  A source register.
- in_srcb  in  ADDR_W  B source register.
- in_dst  in  ADDR_W  destination register.
- in_imm_en  in  1  1: B = in_imm instead of regfile[in_srcb].
- in_imm  in  4  immediate B operand.
- in_nowb  in  1  1: update flags only, no register write.
- alu_a  out  4  registered operand A to ALU.
- alu_b  out  4  registered operand B to ALU.
- alu_opcode  out  4  registered opcode to ALU.
- alu_out  in  4  ALU result.
- alu_z  in  1  ALU Z flag.
- alu_c  in  1  ALU C flag.
- alu_v  in  1  ALU V flag.
- alu_p  in  1  ALU P flag.
- flags_q  out  4  committed flags {Z,C,V,P}.
- done  out  1  one-cycle pulse: instruction committed.
- rd_addr  in  ADDR_W  debug read address.
- rd_data  out  4  combinational regfile[rd_addr].
- clr_sticky  in  1  clears sticky_v (see Optional Feature).
- sticky_v  out  1  sticky overflow (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All regfile entries=RESET_VAL.
  - alu_a=alu_b=alu_opcode=0, flags_q=0, done=0, sticky_v=0.
  - in_ready=1 while in reset, but in_valid is ignored until rst_n=1.
  - Reset mid-instruction aborts it: no write, no done.
- FSM states IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE:
  - in_ready=1.
  - On the edge with in_valid&in_ready, latch op/srca/srcb/dst/imm_en/imm/nowb into internal regs; go READ.
  - Inputs are ignored in any other state.
- READ (in_ready=0):
  - At the edge: alu_a<=regfile[srca], alu_b<=(imm_en ? imm : regfile[srcb]), alu_opcode<=op.
  - Go EXEC.
- EXEC: alu_* stable for the whole cycle. At the edge, capture alu_out and {alu_z,alu_c,alu_v,alu_p} into result regs; go WB.
- WB:
  - At the edge: if !nowb, regfile[dst]<=result; flags_q<=captured flags (always); done<=1; go IDLE.
  - done is high exactly one cycle, coincident with the first IDLE cycle.
- Latency: accept at edge E0 -> commit at E3; done high during cycle E3..E4.
- Throughput: one instruction per 4 cycles; a new accept is legal in the same cycle done is high.
- alu_a/alu_b/alu_opcode hold their last values in IDLE and WB; they change only at the READ edge.
- Hazards: srca/srcb equal to the previous dst read the committed value, since the write precedes READ. dst==srca is legal: read at READ, written at WB.
- rd_data is combinational. During the WB edge it shows the old value; the new value appears after the edge.
- flags_q passes the ALU's C/V unmodified; the ALU already zeroes them for non-arithmetic opcodes.

Optional Feature:
- Macro ALU_SEQ_STICKY_V_EN.
- Defined:
  - sticky_v<=1 at any WB edge whose captured V=1.
  - clr_sticky=1 at an edge clears it; a simultaneous set wins over clear.
  - Reset clears it.
- Undefined: sticky_v tied 0; clr_sticky ignored.
- Port list is identical in both cases.

Test Plan:
- Reset then rd_addr sweep 0..3 -> rd_data=RESET_VAL (0) for all entries; flags_q=0; in_ready=1; done=0.
- Immediate seed: in_op=4'h8, srca=0, imm_en=1, imm=4'h5, dst=1; ALU model returns out=4'h5, flags=0000 -> alu_b=5 during EXEC; done 3 edges after accept; regfile[1]=5.
- Register operands: regfile[1]=5, regfile[2]=3 seeded; op=4'h4, srca=1, srcb=2, dst=3; model returns out=8, V=1 -> alu_a=5, alu_b=3, alu_opcode=4 in EXEC; regfile[3]=8; flags_q=4'b0010.
- nowb=1 with dst=3; model out=0, Z=1 -> regfile[3] unchanged (8); flags_q=4'b1000.
- in_valid held high continuously -> accepts exactly every 4th cycle; in_ready low in READ/EXEC/WB; no double-accept.
- Assert rst_n=0 during EXEC -> outputs/regfile clear immediately; no done. With ALU_SEQ_STICKY_V_EN: V=1 commit sets sticky_v=1; it stays 1 over a V=0 commit and clears on clr_sticky.
